// File: rtl/ss_controller.sv
// Save/restore walker: queries each device slot for a header, then streams its words out to
// the save stream or back in from the restore stream, one acked request at a time.
module ss_controller #(
    parameter int unsigned COUNT   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  restore,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [63:0]           ss_data,
    output logic [23:0]           ss_addr,
    output logic [COUNT-1:0]      ss_select,
    output logic                  ss_write,
    output logic                  ss_read,
    output logic                  ss_query,
    input  logic [64*COUNT-1:0]   ss_dout,
    input  logic [COUNT-1:0]      ss_ack,
    output logic [63:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [63:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready
);

    localparam int unsigned IdxW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle, StQuery, StHeader, StReq, StPush, StPull, StNext, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [63:0]       hdr_q, hdr_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [63:0]       ss_data_q, ss_data_d;
    logic [23:0]       ss_addr_q, ss_addr_d;
    logic [COUNT-1:0]  ss_select_q, ss_select_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic              query_q, query_d;
    logic [63:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    logic [63:0]       dev_dout;
    logic              dev_ack;
    logic              tmr_expired;
    logic              last_word;
    logic              go_error;
    logic [COUNT-1:0]  sel_idx;

    always_comb begin
        dev_dout = '0;
        dev_ack  = 1'b0;
        for (int i = 0; i < COUNT; i++) begin
            if (idx_q == IdxW'(i)) begin
                dev_dout = ss_dout[64*i +: 64];
                dev_ack  = ss_ack[i];
            end
        end
    end

    assign sel_idx     = COUNT'(1) << idx_q;
    assign tmr_expired = (tmr_q == TmrW'(TIMEOUT - 1));
    assign last_word   = (word_q == hdr_q[23:0] - 24'd1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        tmr_d       = tmr_q;
        hdr_d       = hdr_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        ss_data_d   = ss_data_q;
        ss_addr_d   = ss_addr_q;
        ss_select_d = ss_select_q;
        write_d     = write_q;
        read_d      = read_q;
        query_d     = query_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        go_error    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    mode_d      = restore;
                    idx_d       = '0;
                    word_d      = '0;
                    tmr_d       = '0;
                    ss_select_d = COUNT'(1);
                    query_d     = 1'b1;
                    state_d     = StQuery;
                end
            end
            StQuery: begin
                if (dev_ack) begin
                    query_d     = 1'b0;
                    ss_select_d = '0;
                    tmr_d       = '0;
                    hdr_d       = dev_dout;
                    // Counts beyond 24 bits cannot be addressed.
                    if (dev_dout[31:24] != 8'd0) begin
                        go_error = 1'b1;
                    end else begin
                        state_d = StHeader;
                        if (mode_q) begin
                            in_ready_d = 1'b1;
                        end else begin
                            out_valid_d = 1'b1;
                            out_data_d  = dev_dout;
                        end
                    end
                end else if (tmr_expired) begin
                    query_d     = 1'b0;
                    ss_select_d = '0;
                    tmr_d       = '0;
                    state_d     = StNext;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StHeader: begin
                if (!mode_q) begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        if (hdr_q[31:0] == 32'd0) begin
                            state_d = StNext;
                        end else begin
                            read_d      = 1'b1;
                            ss_select_d = sel_idx;
                            ss_addr_d   = word_q;
                            tmr_d       = '0;
                            state_d     = StReq;
                        end
                    end
                end else if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    if (in_data != hdr_q) begin
                        go_error = 1'b1;
                    end else if (hdr_q[31:0] == 32'd0) begin
                        state_d = StNext;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = StPull;
                    end
                end
            end
            StReq: begin
                if (dev_ack) begin
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    ss_select_d = '0;
                    tmr_d       = '0;
                    if (!mode_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = dev_dout;
                        state_d     = StPush;
                    end else if (last_word) begin
                        state_d = StNext;
                    end else begin
                        word_d     = word_q + 24'd1;
                        in_ready_d = 1'b1;
                        state_d    = StPull;
                    end
                end else if (tmr_expired) begin
                    go_error = 1'b1;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StPush: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_word) begin
                        state_d = StNext;
                    end else begin
                        word_d      = word_q + 24'd1;
                        read_d      = 1'b1;
                        ss_select_d = sel_idx;
                        ss_addr_d   = word_q + 24'd1;
                        tmr_d       = '0;
                        state_d     = StReq;
                    end
                end
            end
            StPull: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d  = 1'b0;
                    ss_data_d   = in_data;
                    write_d     = 1'b1;
                    ss_select_d = sel_idx;
                    ss_addr_d   = word_q;
                    tmr_d       = '0;
                    state_d     = StReq;
                end
            end
            StNext: begin
                word_d = '0;
                if (idx_q == IdxW'(COUNT - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    idx_d       = idx_q + IdxW'(1);
                    ss_select_d = COUNT'(1) << (idx_q + IdxW'(1));
                    query_d     = 1'b1;
                    tmr_d       = '0;
                    state_d     = StQuery;
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (go_error) begin
            state_d     = StError;
            error_d     = 1'b1;
            busy_d      = 1'b0;
            query_d     = 1'b0;
            read_d      = 1'b0;
            write_d     = 1'b0;
            ss_select_d = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            word_q      <= '0;
            tmr_q       <= '0;
            hdr_q       <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ss_data_q   <= '0;
            ss_addr_q   <= '0;
            ss_select_q <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            query_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            tmr_q       <= tmr_d;
            hdr_q       <= hdr_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ss_data_q   <= ss_data_d;
            ss_addr_q   <= ss_addr_d;
            ss_select_q <= ss_select_d;
            write_q     <= write_d;
            read_q      <= read_d;
            query_q     <= query_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign ss_data   = ss_data_q;
    assign ss_addr   = ss_addr_q;
    assign ss_select = ss_select_q;
    assign ss_write  = write_q;
    assign ss_read   = read_q;
    assign ss_query  = query_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_ss_controller.sv
// Directed bench for ss_controller with two modelled devices, a save-stream scoreboard and a
// device-write scoreboard.
module tb_ss_controller;

    localparam int unsigned COUNT = 2;
    localparam logic [63:0] Hdr0  = 64'h0000_0001_0000_0003;
    localparam logic [63:0] Hdr0B = 64'h0000_0001_0000_0004;
    localparam logic [63:0] Hdr1  = 64'h0100_0002_0000_0000;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                restore = 1'b0;
    logic                busy, done, error;
    logic [63:0]         ss_data;
    logic [23:0]         ss_addr;
    logic [COUNT-1:0]    ss_select;
    logic                ss_write, ss_read, ss_query;
    logic [64*COUNT-1:0] ss_dout = '0;
    logic [COUNT-1:0]    ss_ack = '0;
    logic [63:0]         out_data;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [63:0]         in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;

    int checks = 0;
    int errors = 0;

    logic [63:0]  exp_out[$];
    logic [127:0] exp_wr[$];
    logic [63:0]  in_q[$];
    logic [63:0]  mem0[3];
    logic [63:0]  hdrs[2];
    logic [COUNT-1:0] present = 2'b11;
    logic [COUNT-1:0] nack;
    logic         toggle = 1'b0;
    logic         hold_pend = 1'b0;
    logic [63:0]  held;
    int           done_cnt = 0;
    int           q1_cnt = 0;

    ss_controller #(.COUNT(COUNT), .TIMEOUT(255)) dut (
        .clock(clock), .reset(reset), .start(start), .restore(restore),
        .busy(busy), .done(done), .error(error),
        .ss_data(ss_data), .ss_addr(ss_addr), .ss_select(ss_select),
        .ss_write(ss_write), .ss_read(ss_read), .ss_query(ss_query),
        .ss_dout(ss_dout), .ss_ack(ss_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Device model: acks one request per strobe, answering on the falling edge.
    always @(negedge clock) begin
        logic [127:0] e;
        for (int i = 0; i < COUNT; i++) begin
            nack[i] = 1'b0;
            if (!reset && present[i] && ss_select[i] && !ss_ack[i] &&
                (ss_query || ss_read || ss_write)) begin
                nack[i] = 1'b1;
                if (ss_query) begin
                    ss_dout[64*i +: 64] = hdrs[i];
                end else if (ss_read) begin
                    ss_dout[64*i +: 64] = (i == 0 && ss_addr < 24'd3) ? mem0[ss_addr[1:0]] : '0;
                end else begin
                    e = (exp_wr.size() != 0) ? exp_wr.pop_front() : '1;
                    chk("dev_write", {32'(i), 8'd0, ss_addr, ss_data}, e);
                end
            end
        end
        ss_ack = nack;
    end

    // Save-stream scoreboard and hold-stability monitor.
    always @(negedge clock) begin
        logic [63:0] e;
        if (hold_pend) begin
            chk("out_hold_valid", {127'd0, out_valid}, 128'd1);
            chk("out_hold_data", {64'd0, out_data}, {64'd0, held});
        end
        if (out_valid && out_ready) begin
            e = (exp_out.size() != 0) ? exp_out.pop_front() : '1;
            chk("out_stream", {64'd0, out_data}, {64'd0, e});
        end
        hold_pend = out_valid && !out_ready;
        held      = out_data;
        if (done) done_cnt++;
        if (ss_query && ss_select[1]) q1_cnt++;
    end

    // Restore-stream source.
    always @(negedge clock) begin
        if (in_valid && in_ready) begin
            @(posedge clock);
            #1;
            void'(in_q.pop_front());
        end
        in_valid = (in_q.size() != 0);
        if (in_valid) in_data = in_q[0];
        else in_data = '0;
    end

    always @(posedge clock) begin
        #1;
        if (toggle) out_ready = ~out_ready;
    end

    task automatic start_pass(input logic mode);
        @(negedge clock);
        start   = 1'b1;
        restore = mode;
        @(negedge clock);
        start   = 1'b0;
        chk("busy_after_start", {127'd0, busy}, 128'd1);
    endtask

    task automatic wait_pass(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("pass_in_budget", {127'd0, n < budget}, 128'd1);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        mem0[0] = 64'h11; mem0[1] = 64'h22; mem0[2] = 64'h33;
        hdrs[0] = Hdr0;   hdrs[1] = Hdr1;

        repeat (3) @(negedge clock);
        chk("rst_busy_done_err", {125'd0, busy, done, error}, 128'd0);
        chk("rst_strobes_sel", {123'd0, ss_select, ss_write, ss_read, ss_query}, 128'd0);
        chk("rst_stream", {126'd0, out_valid, in_ready}, 128'd0);
        chk("rst_data_addr", {40'd0, ss_addr, ss_data}, 128'd0);
        reset = 1'b0;
        @(negedge clock);

        // Save pass
        done_cnt = 0;
        exp_out = '{Hdr0, 64'h11, 64'h22, 64'h33, Hdr1};
        start_pass(1'b0);
        chk("save_first_sel", {126'd0, ss_select}, 128'd1);
        wait_pass(500);
        chk("save_done_cnt", 128'(done_cnt), 128'd1);
        chk("save_error", {127'd0, error}, 128'd0);
        chk("save_left", 128'(exp_out.size()), 128'd0);
        chk("save_idle_sel", {126'd0, ss_select}, 128'd0);

        // Restore the same stream
        done_cnt = 0;
        in_q   = '{Hdr0, 64'h11, 64'h22, 64'h33, Hdr1};
        exp_wr = '{{32'd0, 32'd0, 64'h11}, {32'd0, 32'd1, 64'h22}, {32'd0, 32'd2, 64'h33}};
        start_pass(1'b1);
        wait_pass(500);
        chk("rest_done_cnt", 128'(done_cnt), 128'd1);
        chk("rest_error", {127'd0, error}, 128'd0);
        chk("rest_writes_left", 128'(exp_wr.size()), 128'd0);
        chk("rest_in_left", 128'(in_q.size()), 128'd0);

        // Restore with a mismatching header
        done_cnt = 0;
        in_q = '{Hdr0B, 64'h11, 64'h22, 64'h33, Hdr1};
        start_pass(1'b1);
        wait_pass(500);
        chk("bad_error", {127'd0, error}, 128'd1);
        chk("bad_busy", {127'd0, busy}, 128'd0);
        chk("bad_done_cnt", 128'(done_cnt), 128'd0);
        chk("bad_in_ready", {127'd0, in_ready}, 128'd0);
        in_q.delete();
        repeat (2) @(negedge clock);

        // Device 1 absent: query times out after 255 cycles
        done_cnt = 0;
        q1_cnt   = 0;
        present  = 2'b01;
        exp_out  = '{Hdr0, 64'h11, 64'h22, 64'h33};
        start_pass(1'b0);
        chk("abs_error_cleared", {127'd0, error}, 128'd0);
        wait_pass(2000);
        chk("abs_query_cycles", 128'(q1_cnt), 128'd255);
        chk("abs_done_cnt", 128'(done_cnt), 128'd1);
        chk("abs_error", {127'd0, error}, 128'd0);
        chk("abs_left", 128'(exp_out.size()), 128'd0);
        present = 2'b11;

        // Save with toggling backpressure
        done_cnt = 0;
        toggle   = 1'b1;
        exp_out  = '{Hdr0, 64'h11, 64'h22, 64'h33, Hdr1};
        start_pass(1'b0);
        wait_pass(500);
        toggle = 1'b0;
        @(negedge clock);
        out_ready = 1'b1;
        chk("bp_done_cnt", 128'(done_cnt), 128'd1);
        chk("bp_left", 128'(exp_out.size()), 128'd0);

        // Reset in the middle of device 0 word 1
        begin
            int n = 0;
            done_cnt = 0;
            exp_out  = '{Hdr0, 64'h11, 64'h22, 64'h33, Hdr1};
            start_pass(1'b0);
            while (!(ss_read && ss_addr == 24'd1) && n < 100) begin
                @(negedge clock);
                n++;
            end
            chk("mid_reached_word1", {127'd0, n < 100}, 128'd1);
            reset = 1'b1;
            #1;
            chk("mid_async_ctl", {123'd0, busy, ss_read, ss_query, out_valid, error}, 128'd0);
            chk("mid_async_sel_addr", {102'd0, ss_select, ss_addr}, 128'd0);
            exp_out.delete();
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            chk("mid_no_done", 128'(done_cnt), 128'd0);
            exp_out = '{Hdr0, 64'h11, 64'h22, 64'h33, Hdr1};
            start_pass(1'b0);
            chk("mid_requery_dev0", {125'd0, ss_query, ss_select}, 128'b101);
            wait_pass(500);
            chk("mid_done_cnt", 128'(done_cnt), 128'd1);
            chk("mid_left", 128'(exp_out.size()), 128'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ss_controller.md
SS_CONTROLLER -- requirements
Module: ss_controller

Interface
REQ-001 Parameter COUNT, default 8: number of ss2device_if slots walked, indices 0..COUNT-1.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for a device ack.
REQ-003 clock  in  1  sole clock; every register is updated on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that begins a pass; ignored while busy.
REQ-006 restore  in  1  sampled on start: 0 = save (devices to out stream), 1 = restore (in stream to devices).
REQ-007 busy  out  1  high from the cycle after start until done or error.
REQ-008 done  out  1  one-cycle pulse when a pass completes without error.
REQ-009 error  out  1  sticky; cleared on the next accepted start.
REQ-010 ss_data  out  64  write data to devices.
REQ-011 ss_addr  out  24  word address within the selected device.
REQ-012 ss_select  out  COUNT  one-hot device select; all zero when idle.
REQ-013 ss_write, ss_read, ss_query  out  1 each  request strobes; at most one is high at a time.
REQ-014 ss_dout  in  64*COUNT  device responses, slot i at bits [64*i+63:64*i].
REQ-015 ss_ack  in  COUNT  per-device one-cycle acknowledge.
REQ-016 out_data  out  64 / out_valid  out  1 / out_ready  in  1  save stream with valid/ready handshake.
REQ-017 in_data  in  64 / in_valid  in  1 / in_ready  out  1  restore stream with valid/ready handshake.

Function
REQ-018 States: IDLE, QUERY, HEADER, REQ, PUSH, PULL, NEXT, DONE, ERROR.
REQ-019 QUERY: drive ss_select[idx] and ss_query until ss_ack[idx]; latch ss_dout slot idx as hdr; deassert the strobe in the ack cycle.
REQ-020 hdr fields: [63:56] idx, [33:32] width, [31:0] count; the width field is carried and not interpreted.
REQ-021 No ack within TIMEOUT cycles in QUERY: the device is absent, and the controller goes to NEXT with no stream traffic.
REQ-022 Save HEADER: present hdr on out_data with out_valid high; advance on out_valid&out_ready.
REQ-023 Restore HEADER: assert in_ready; on in_valid, in_data must equal hdr, otherwise go to ERROR.
REQ-024 hdr[31:24] nonzero: go to ERROR, because count exceeds the 24-bit address space.
REQ-025 count 0: go from HEADER straight to NEXT.
REQ-026 Save REQ: drive ss_read, ss_addr = word, held until ack; latch ss_dout slot idx; then PUSH the word to the out stream.
REQ-027 Restore: PULL one in-stream word (in_ready high only in PULL), then REQ with ss_write, ss_data = that word, held until ack.
REQ-028 Ack timeout in REQ is an error: go to ERROR.
REQ-029 After each acked transfer, increment word; when word == count-1 completes, go to NEXT.
REQ-030 NEXT: increment idx; after idx == COUNT-1, go to DONE, which pulses done for one cycle and returns to IDLE.
REQ-031 ERROR: set error, drop all strobes, selects, out_valid and in_ready, and return to IDLE the next cycle.
REQ-032 out_valid, once raised, holds with stable out_data until accepted.
REQ-033 Throughput: a device read takes at least 2 cycles (request, ack); backpressure stalls only PUSH/PULL.
REQ-034 The timeout counter clears on each new request and on every ack.

Reset
REQ-035 On reset: state IDLE, idx 0, word 0, and every output low or zero (busy, done, error, strobes, ss_select, out_valid, in_ready, ss_data, ss_addr).
REQ-036 Reset mid-pass aborts immediately without a done pulse; the next start begins again at device 0.

Verification
REQ-037 Save, COUNT=2, dev0 count=3 returning 0x11,0x22,0x33, dev1 count=0, out_ready=1 -> stream hdr0,0x11,0x22,0x33,hdr1; done pulses once.
REQ-038 Restore the same stream with matching headers -> dev0 sees writes at addr 0,1,2 with 0x11,0x22,0x33; no error.
REQ-039 Restore with hdr0 count field altered to 4 -> error=1, no ss_write issued, busy falls.
REQ-040 Device 1 never acks a query, TIMEOUT=255 -> the query strobe drops after 255 cycles, device 1 is skipped, done pulses.
REQ-041 Save with out_ready toggling 1/0 every cycle -> out_data stable while out_valid & !out_ready; stream identical to REQ-037.
REQ-042 Reset asserted during dev0 word 1 -> outputs zero asynchronously; a new start re-queries device 0.
